imem_fetch_unit: RTL

Parametrised, loadable instruction memory with a registered fetch port, replacing the fixed-size, file-preloaded, combinational-read instruction store. A streaming load port writes the program at run time, and the block records the program length. The fetch side uses a req/ready/valid handshake with 1-cycle latency, stall hold and out-of-range fault detection. It sits between the PC/fetch stage and decode.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_array.sv | 24 ++
 rtl/imem_fetch_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory and its consumers.
// Holds the fetch-unit state type, default geometry and the NOP encoding.
package imem_pkg;

  localparam int unsigned INSTR_W_DEF = 9;
  localparam int unsigned DEPTH_DEF   = 4096;

  localparam logic [INSTR_W_DEF-1:0] NOP = '0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FAULT
  } state_t;

endpackage

// File: rtl/imem_array.sv
// Single-write, single-read synchronous RAM with registered read data.
// Read data holds its value whenever the read enable is low.
module imem_array #(
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Loadable instruction memory with a streaming load port and a registered
// req/ready/valid fetch port featuring stall hold and out-of-range faulting.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned ADDR_W  = $clog2(DEPTH),
  parameter int unsigned PC_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               load_ovf,
  output logic [ADDR_W:0]    prog_len,
  input  logic               fetch_req,
  input  logic [PC_W-1:0]    fetch_pc,
  output logic               fetch_ready,
  input  logic               stall,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_fault
);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  wptr;
  logic [INSTR_W-1:0] rd_data;
  logic               nop_sel;
  logic               in_range, accept, enter_load, last_slot, mem_we, mem_re;

  assign in_range   = (fetch_pc[PC_W-1:ADDR_W] == '0) &&
                      ({1'b0, fetch_pc[ADDR_W-1:0]} < prog_len);
  assign accept     = fetch_req && fetch_ready;
  assign enter_load = load_en && (state != LOAD);
  assign last_slot  = (wptr == ADDR_W'(DEPTH - 1));
  assign mem_we     = load_ready && load_valid;
  assign mem_re     = accept && in_range;

  // RAM output is held by its read enable; nop_sel substitutes NOP after reset or a fault.
  assign instr = nop_sel ? INSTR_W'(NOP) : rd_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_en) state_nxt = LOAD;
      LOAD:    if (load_valid && (load_last || last_slot)) state_nxt = RUN;
      RUN: begin
        if (load_en)                  state_nxt = LOAD;
        else if (accept && !in_range) state_nxt = FAULT;
      end
      FAULT:   if (load_en) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready  = 1'b0;
    fetch_ready = 1'b0;
    case (state)
      LOAD:    load_ready  = 1'b1;
      RUN:     fetch_ready = !stall && !load_en;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr        <= '0;
      prog_len    <= '0;
      load_ovf    <= 1'b0;
      instr_fault <= 1'b0;
      instr_valid <= 1'b0;
      nop_sel     <= 1'b1;
    end else if (enter_load) begin
      wptr        <= '0;
      prog_len    <= '0;
      load_ovf    <= 1'b0;
      instr_fault <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          instr_valid <= 1'b0;
          if (load_valid) begin
            wptr <= wptr + ADDR_W'(1);
            if (load_last) begin
              prog_len <= {1'b0, wptr} + (ADDR_W + 1)'(1);
            end else if (last_slot) begin
              prog_len <= (ADDR_W + 1)'(DEPTH);
              load_ovf <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            instr_valid <= 1'b1;
            nop_sel     <= !in_range;
            if (!in_range) instr_fault <= 1'b1;
          end else if (!stall) begin
            instr_valid <= 1'b0;
          end
        end
        default: instr_valid <= 1'b0;
      endcase
    end
  end

  imem_array #(
    .INSTR_W(INSTR_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wptr),
    .wdata(load_data),
    .re   (mem_re),
    .raddr(fetch_pc[ADDR_W-1:0]),
    .rdata(rd_data)
  );

endmodule
